// File: rtl/sdram_wr_buf.sv
// sdram_wr_buf
// ------------
// Buffers a 16-bit user write stream for the SDRAM write path.
// Words are queued in a show-ahead FIFO. Once a full burst is buffered, the
// block raises a one-cycle wr_trig together with wr_len and wr_addr. The
// write engine then takes words from wr_data by pulsing wr_data_en. When the
// engine reports flag_wr_end, the burst address advances through a circular
// region.
//
// Ports
//   sclk         in   system clock
//   srst_n       in   asynchronous active-low reset
//   din          in   [15:0] user write data
//   din_vld      in   user data valid
//   din_rdy      out  buffer can accept (not full)
//   wr_trig      out  one-cycle burst request to the write engine
//   wr_len       out  [7:0] burst length (constant BURST_LEN)
//   wr_addr      out  [20:0] burst start word address {bank,row,col}
//   wr_data_en   in   write engine consumes wr_data this cycle
//   wr_data      out  [15:0] FIFO head word (0 when empty)
//   flag_wr_end  in   write engine finished the current burst
//   fill         out  [$clog2(FIFO_DEPTH):0] FIFO occupancy
//   overflow     out  sticky: din_vld seen while full
//   underrun     out  sticky: wr_data_en seen while empty
//   o_state      out  [1:0] FSM state (0 IDLE, 1 TRIG, 2 BUSY) for debug
//
// Handshake: a word is pushed on a clock edge where din_vld && din_rdy.
// A word is popped on a clock edge where wr_data_en && fill != 0.
// Neither input is required to wait for the other.

module sdram_wr_buf #(
    parameter int          FIFO_DEPTH = 512,
    parameter int          BURST_LEN  = 8,
    parameter logic [20:0] BASE_ADDR  = 21'd0,
    parameter logic [20:0] REGION_LEN = 21'd4096,
    localparam int         AW         = $clog2(FIFO_DEPTH),
    localparam int         FW         = AW + 1
) (
    input  logic          sclk,
    input  logic          srst_n,
    input  logic [15:0]   din,
    input  logic          din_vld,
    output logic          din_rdy,
    output logic          wr_trig,
    output logic [7:0]    wr_len,
    output logic [20:0]   wr_addr,
    input  logic          wr_data_en,
    output logic [15:0]   wr_data,
    input  logic          flag_wr_end,
    output logic [FW-1:0] fill,
    output logic          overflow,
    output logic          underrun,
    output logic [1:0]    o_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TRIG = 2'd1;
    localparam logic [1:0] S_BUSY = 2'd2;

    localparam logic [FW-1:0] FULL_LVL   = FW'(FIFO_DEPTH);
    localparam logic [FW-1:0] BURST_LVL  = FW'(BURST_LEN);
    localparam logic [20:0]   BURST_STEP = 21'(BURST_LEN);
    // One past the last burst start in the region. The compare uses the full
    // 21-bit sum, so a region that ends exactly at 2^21 wraps through zero.
    localparam logic [20:0]   END_ADDR   = BASE_ADDR + REGION_LEN;

    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [FW-1:0] r_fill;
    logic [1:0]    r_state;
    logic [20:0]   r_wr_addr;
    logic          r_overflow;
    logic          r_underrun;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [20:0]   w_addr_inc;

    assign w_full     = (r_fill == FULL_LVL);
    assign w_empty    = (r_fill == '0);
    assign w_push     = din_vld && !w_full;
    assign w_pop      = wr_data_en && !w_empty;
    assign w_addr_inc = r_wr_addr + BURST_STEP;

    assign din_rdy  = !w_full;
    assign wr_trig  = (r_state == S_TRIG);
    assign wr_len   = 8'(BURST_LEN);
    assign wr_addr  = r_wr_addr;
    // Show-ahead head word. It is gated to zero when empty, so stale storage
    // (including words left over from before a reset) never leaks out.
    assign wr_data  = w_empty ? 16'd0 : r_mem[r_rd_ptr];
    assign fill     = r_fill;
    assign overflow = r_overflow;
    assign underrun = r_underrun;
    assign o_state  = r_state;

    // Storage has no reset. Reset only clears the pointers and the fill
    // count, which discards any buffered contents.
    always_ff @(posedge sclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_overflow <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
            if (din_vld && w_full) begin
                r_overflow <= 1'b1;
            end
            if (wr_data_en && w_empty) begin
                r_underrun <= 1'b1;
            end
        end
    end

    // Burst sequencing. TRIG lasts exactly one cycle. Because IDLE always
    // lasts at least one cycle, consecutive triggers are at least three
    // cycles apart.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_state   <= S_IDLE;
            r_wr_addr <= BASE_ADDR;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_fill >= BURST_LVL) begin
                        r_state <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    r_state <= S_BUSY;
                end
                S_BUSY: begin
                    if (flag_wr_end) begin
                        r_state   <= S_IDLE;
                        r_wr_addr <= (w_addr_inc == END_ADDR) ? BASE_ADDR : w_addr_inc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
